clk_monitor: RTL and testbench
==============================

Name: clk_monitor

Overview:
- Receiving end of the divided clock produced by the clock divider.
- Samples a toggling clock signal (divider output or external slow clock) as data in the fast `clk` domain, synchronizes it and detects its rising and falling edges.
- Measures the half-period in `clk` cycles and reports lock to an expected rate, loss of clock and error events.
- Downstream logic uses the `rise`/`fall` pulses as clock enables instead of clocking flops from a derived clock.

Parameters:
- SYNC_STAGES, 2: synchronizer flop count on clk_in (minimum 2).
- CNT_W, 16: width of the half-period counter and half_period output.
- EXP_HALF, 1: expected half-period, in clk cycles.
- TOL, 0: allowed absolute deviation from EXP_HALF, in clk cycles.
- LOCK_EDGES, 4: consecutive in-tolerance edges needed to assert locked.
- TIMEOUT, 64: clk cycles without an edge before declaring loss (must be less than 2^CNT_W).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk_in  in  1  monitored clock, treated as asynchronous data.
- en  in  1  monitor enable.
- rise  out  1  one-cycle pulse per synchronized rising edge.
- fall  out  1  one-cycle pulse per synchronized falling edge.
- half_period  out  CNT_W  last measured edge-to-edge interval.
- locked  out  1  rate within tolerance for LOCK_EDGES consecutive edges.
- lost  out  1  no edge seen for TIMEOUT cycles.
- err_cnt  out  8  out-of-tolerance edge count, saturating at 255.

Behaviour:
- Reset and synchronicity: one clock; reset is synchronous and active-high, ports named `clk` and `rst`. While rst=1 at a clk edge, every register clears:
  - sync chain, prev, cnt, good_cnt = 0
  - rise, fall, half_period, locked, lost, err_cnt = 0
  - state = IDLE
- Synchronizer: clk_in passes through SYNC_STAGES flops; s = last stage; prev = s delayed one cycle.
- Edge detect:
  - edge = (s != prev); rise_d = s & ~prev; fall_d = ~s & prev.
  - rise/fall are registered and gated by en.
  - Latency from a clk_in change to the rise/fall pulse is SYNC_STAGES+1 clk cycles.
- Counter:
  - No edge: cnt increments, saturating at all-ones.
  - Edge: meas = cnt+1 (saturating), cnt <= 0.
  - A clk_in toggling every clk cycle gives meas = 1.
- Update and check:
  - half_period <= meas on every counted edge; it is not updated in IDLE.
  - In-tolerance test is |meas - EXP_HALF| <= TOL, computed unsigned, CNT_W+1 bits.
- State machine (en=0 in any state forces IDLE on the next cycle):
  - IDLE: cnt, good_cnt, err_cnt, locked, lost held at 0. en=1 goes to SEEK.
  - SEEK: waits for the first edge. That edge's meas is discarded for checking; go to TRACK with good_cnt=0.
  - TRACK:
    - Good edge: good_cnt++; when good_cnt reaches LOCK_EDGES, go to LOCKED and set locked=1 in the same cycle.
    - Bad edge: good_cnt=0, err_cnt++ (saturating).
  - LOCKED: a bad edge sets err_cnt++, locked=0, good_cnt=0 and returns to TRACK.
  - Timeout: in SEEK, TRACK or LOCKED, when cnt == TIMEOUT-1 and there is no edge, go to LOST with lost=1 and locked=0.
  - LOST: the next edge goes to TRACK with its meas discarded and lost=0 on the same cycle.
- Simultaneous events:
  - An edge in the timeout cycle: the edge wins, no loss.
  - rst takes priority over en, which takes priority over everything else.
  - rst mid-LOCKED clears all outputs on the next cycle; no stale pulse is emitted.
- Saturation: err_cnt holds at 255; cnt holds at all-ones while in LOST.

Decomposition:
- Shared package `clk_pkg`:
  - state encoding typedef (IDLE, SEEK, TRACK, LOCKED, LOST)
  - ERR_W = 8 constant
  - default SYNC_STAGES value
- One sub-module: `sync_edge`, containing the synchronizer, prev flop and rise/fall detect. It is reusable for other asynchronous inputs.
- clk_monitor contains the counter, tolerance check and FSM.

Test Plan:
- Lock from divider: en=1, clk_in driven by a divider toggling every cycle.
  - rise/fall alternate each cycle, first pulse 3 cycles after the first toggle.
  - half_period=1; locked=1 on the 5th edge (1 discarded + 4 good).
- Loss: while locked, hold clk_in constant.
  - lost=1 and locked=0 exactly 64 cycles after the last edge pulse.
  - One toggle then gives lost=0 in TRACK; locked returns after 4 further good edges.
- Glitch: while locked, stretch one half-period to 3 cycles (EXP_HALF=1, TOL=0).
  - half_period=3, err_cnt=1, locked=0.
  - Relock after 4 good edges.
- Reset mid-operation: assert rst for 1 cycle while locked with err_cnt=2.
  - The next cycle shows all outputs 0 and state IDLE.
- Enable drop: en=0 while toggling.
  - No rise/fall pulses; locked/lost/err_cnt=0 from the next cycle.
  - Re-enabling restarts from SEEK.
- Error saturation: 300 consecutive out-of-tolerance edges leave err_cnt=255 and locked=0.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared definitions for the clock monitor: FSM state encoding and widths.
// Imported by sync_edge and clk_monitor.
package clk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    TRACK,
    LOCKED,
    LOST
  } state_t;

  localparam int ERR_W           = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// Synchronizes an asynchronous level into the clk domain and detects its edges.
// Reusable for any slow asynchronous input; rise/fall are registered and gated by en.
module sync_edge
  import clk_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic toggle,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              s;
  logic              prev;

  assign s      = sync[STAGES-1];
  assign toggle = s ^ prev;

  // Pulses are registered so they line up with the FSM's reaction to the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= s;
      rise <= s & ~prev & en;
      fall <= ~s & prev & en;
    end
  end

endmodule

// File: rtl/clk_monitor.sv
// Monitors a slow toggling clock sampled as data: measures its half-period,
// reports lock to an expected rate, loss of clock and out-of-tolerance edges.
module clk_monitor
  import clk_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = 16,
  parameter int EXP_HALF    = 1,
  parameter int TOL         = 0,
  parameter int LOCK_EDGES  = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             en,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] half_period,
  output logic             locked,
  output logic             lost,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int                GOOD_W       = $clog2(LOCK_EDGES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX      = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]    EXP_EXT      = (CNT_W + 1)'(EXP_HALF);
  localparam logic [CNT_W:0]    TOL_EXT      = (CNT_W + 1)'(TOL);
  localparam logic [GOOD_W-1:0] GOOD_TARGET  = GOOD_W'(LOCK_EDGES);

  state_t            state;
  state_t            state_nxt;
  logic              toggle;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  meas;
  logic [CNT_W-1:0]  hp_nxt;
  logic [CNT_W:0]    meas_ext;
  logic [CNT_W:0]    diff;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_nxt;
  logic [GOOD_W-1:0] good_inc;
  logic [ERR_W-1:0]  err_nxt;
  logic              locked_nxt;
  logic              lost_nxt;
  logic              in_tol;
  logic              timeout_hit;

  sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (clk_in),
    .en    (en),
    .toggle(toggle),
    .rise  (rise),
    .fall  (fall)
  );

  // meas doubles as the saturating increment of cnt on cycles without an edge.
  assign meas        = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  assign meas_ext    = {1'b0, meas};
  assign diff        = (meas_ext >= EXP_EXT) ? meas_ext - EXP_EXT : EXP_EXT - meas_ext;
  assign in_tol      = (diff <= TOL_EXT);
  assign timeout_hit = !toggle && (cnt == TIMEOUT_LAST);
  assign good_inc    = good_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:   state_nxt = SEEK;
        SEEK: begin
          if (toggle)           state_nxt = TRACK;
          else if (timeout_hit) state_nxt = LOST;
        end
        TRACK: begin
          if (toggle) begin
            if (in_tol && good_inc == GOOD_TARGET) state_nxt = LOCKED;
          end else if (timeout_hit) begin
            state_nxt = LOST;
          end
        end
        LOCKED: begin
          if (toggle && !in_tol) state_nxt = TRACK;
          else if (timeout_hit)  state_nxt = LOST;
        end
        LOST: begin
          if (toggle) state_nxt = TRACK;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Edges seen in SEEK or LOST only restart the measurement; they are never judged.
  always_comb begin
    cnt_nxt    = '0;
    good_nxt   = '0;
    err_nxt    = '0;
    hp_nxt     = half_period;
    locked_nxt = (state_nxt == LOCKED);
    lost_nxt   = (state_nxt == LOST);
    if (en && state != IDLE) begin
      err_nxt  = err_cnt;
      good_nxt = good_cnt;
      if (toggle) begin
        hp_nxt = meas;
        if (state == TRACK || state == LOCKED) begin
          if (in_tol) begin
            if (state == TRACK) good_nxt = good_inc;
          end else begin
            good_nxt = '0;
            if (err_cnt != '1) err_nxt = err_cnt + 1'b1;
          end
        end else begin
          good_nxt = '0;
        end
      end else begin
        cnt_nxt = meas;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      good_cnt    <= '0;
      half_period <= '0;
      locked      <= 1'b0;
      lost        <= 1'b0;
      err_cnt     <= '0;
    end else begin
      cnt         <= cnt_nxt;
      good_cnt    <= good_nxt;
      half_period <= hp_nxt;
      locked      <= locked_nxt;
      lost        <= lost_nxt;
      err_cnt     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor: lock, loss, glitch, reset, enable drop and
// error saturation with hand-computed expectations at fixed cycle offsets.
module tb_clk_monitor;
  import clk_pkg::*;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        clk_in = 1'b0;
  logic        en     = 1'b0;
  logic        rise;
  logic        fall;
  logic [15:0] half_period;
  logic        locked;
  logic        lost;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clk_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .clk_in     (clk_in),
    .en         (en),
    .rise       (rise),
    .fall       (fall),
    .half_period(half_period),
    .locked     (locked),
    .lost       (lost),
    .err_cnt    (err_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
  task automatic applyStimulus(input logic r, input logic e, input logic ci);
    rst    = r;
    en     = e;
    clk_in = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic lockRun(input bit from_lost);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b1, ~clk_in);
      if (k == 2) begin
        checkOutput("lock_no_early_rise", 32'(rise), 32'd0);
        checkOutput("lock_no_early_fall", 32'(fall), 32'd0);
        if (from_lost) checkOutput("lost_held", 32'(lost), 32'd1);
      end
      if (k == 3) begin
        checkOutput("lock_first_rise", 32'(rise), 32'd1);
        checkOutput("lock_first_nofall", 32'(fall), 32'd0);
        checkOutput("lock_lost_clear", 32'(lost), 32'd0);
      end
      if (k == 4) begin
        checkOutput("lock_fall", 32'(fall), 32'd1);
        checkOutput("lock_norise", 32'(rise), 32'd0);
        checkOutput("lock_half_period", 32'(half_period), 32'd1);
      end
      if (k == 6) checkOutput("lock_not_yet", 32'(locked), 32'd0);
      if (k == 7) checkOutput("lock_5th_edge", 32'(locked), 32'd1);
    end
  endtask

  task automatic glitchRun(input int exp_err);
    for (int k = 1; k <= 10; k++) begin
      if (k == 2 || k == 3) applyStimulus(1'b0, 1'b1, clk_in);
      else                  applyStimulus(1'b0, 1'b1, ~clk_in);
      if (k == 5) checkOutput("glitch_pre_locked", 32'(locked), 32'd1);
      if (k == 6) begin
        checkOutput("glitch_half_period", 32'(half_period), 32'd3);
        checkOutput("glitch_err_cnt", 32'(err_cnt), 32'(exp_err));
        checkOutput("glitch_unlock", 32'(locked), 32'd0);
      end
      if (k == 9) checkOutput("glitch_relock_wait", 32'(locked), 32'd0);
      if (k == 10) begin
        checkOutput("glitch_relock", 32'(locked), 32'd1);
        checkOutput("glitch_hp_back", 32'(half_period), 32'd1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rst_rise", 32'(rise), 32'd0);
    checkOutput("rst_fall", 32'(fall), 32'd0);
    checkOutput("rst_half_period", 32'(half_period), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_lost", 32'(lost), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("rst_state", 32'(dut.state), 32'(IDLE));

    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("en_to_seek", 32'(dut.state), 32'(SEEK));
    lockRun(1'b0);

    // Hold clk_in: loss must be flagged 64 cycles after the last edge pulse.
    for (int j = 1; j <= 66; j++) begin
      applyStimulus(1'b0, 1'b1, clk_in);
      if (j == 2) checkOutput("loss_last_fall", 32'(fall), 32'd1);
      if (j == 65) begin
        checkOutput("loss_not_yet", 32'(lost), 32'd0);
        checkOutput("loss_still_locked", 32'(locked), 32'd1);
      end
      if (j == 66) begin
        checkOutput("loss_flag", 32'(lost), 32'd1);
        checkOutput("loss_unlock", 32'(locked), 32'd0);
        checkOutput("loss_state", 32'(dut.state), 32'(LOST));
      end
    end
    lockRun(1'b1);

    glitchRun(1);
    glitchRun(2);

    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("midrst_rise", 32'(rise), 32'd0);
    checkOutput("midrst_fall", 32'(fall), 32'd0);
    checkOutput("midrst_half_period", 32'(half_period), 32'd0);
    checkOutput("midrst_locked", 32'(locked), 32'd0);
    checkOutput("midrst_lost", 32'(lost), 32'd0);
    checkOutput("midrst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("midrst_state", 32'(dut.state), 32'(IDLE));
    for (int j = 1; j <= 2; j++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("postrst_no_rise", 32'(rise), 32'd0);
      checkOutput("postrst_no_fall", 32'(fall), 32'd0);
    end

    lockRun(1'b0);
    glitchRun(1);

    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b0, ~clk_in);
      checkOutput("endrop_rise", 32'(rise), 32'd0);
      checkOutput("endrop_fall", 32'(fall), 32'd0);
      checkOutput("endrop_locked", 32'(locked), 32'd0);
      checkOutput("endrop_lost", 32'(lost), 32'd0);
      checkOutput("endrop_err_cnt", 32'(err_cnt), 32'd0);
    end
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b1, ~clk_in);
      if (k == 1) checkOutput("reen_seek", 32'(dut.state), 32'(SEEK));
      if (k == 2) checkOutput("reen_track", 32'(dut.state), 32'(TRACK));
      if (k == 5) checkOutput("reen_not_locked", 32'(locked), 32'd0);
      if (k == 6) begin
        checkOutput("reen_locked", 32'(locked), 32'd1);
        checkOutput("reen_err_cnt", 32'(err_cnt), 32'd0);
      end
    end

    // Half-period of 2 is out of tolerance on every edge: err_cnt must saturate.
    for (int k = 1; k <= 610; k++) begin
      if (k % 2 == 0) applyStimulus(1'b0, 1'b1, ~clk_in);
      else            applyStimulus(1'b0, 1'b1, clk_in);
      if (k == 3) checkOutput("sat_pre_locked", 32'(locked), 32'd1);
      if (k == 4) begin
        checkOutput("sat_first_err", 32'(err_cnt), 32'd1);
        checkOutput("sat_first_unlock", 32'(locked), 32'd0);
        checkOutput("sat_half_period", 32'(half_period), 32'd2);
      end
      if (k == 610) begin
        checkOutput("sat_err_cnt", 32'(err_cnt), 32'd255);
        checkOutput("sat_locked", 32'(locked), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
